// File: rtl/wb_l10_pkg.sv
// Shared types and constants for the layer 10-16 writeback controller.
// Saturation bounds are exposed as functions so any data width can reuse them.
package wb_l10_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } wb_state_t;

  localparam int         FMAP_DIM = 8;
  localparam logic [1:0] XP_LAST  = 2'd3;
  localparam logic [2:0] Y_LAST   = 3'd7;
  localparam logic [2:0] U_SKIP   = 3'd4;
  localparam logic [2:0] U_MAX    = 3'd4;

  // Largest positive two's-complement value of width dw (low dw bits).
  function automatic logic [63:0] sat_hi(input int unsigned dw);
    return (64'd1 << (dw - 32'd1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width dw (low dw bits).
  function automatic logic [63:0] sat_lo(input int unsigned dw);
    return {64{1'b1}} << (dw - 32'd1);
  endfunction

endpackage

// File: rtl/wb_lane_post.sv
// Per-lane write-data post-processing: optional skip add, saturation, and
// ReLU clamp when built with WB_RELU_EN.
module wb_lane_post
  import wb_l10_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] res,
  input  logic signed [DW-1:0] skip,
  input  logic                 skip_en,
  output logic signed [DW-1:0] post_data
);

  localparam logic signed [DW-1:0] SAT_HI = DW'(sat_hi(DW));
  localparam logic signed [DW-1:0] SAT_LO = DW'(sat_lo(DW));

  logic signed [DW:0]   sum_s;
  logic signed [DW-1:0] sat_s;

  // Widen by one bit so overflow shows up as a mismatch of the top two bits.
  always_comb begin
    sum_s = {res[DW-1], res} + (skip_en ? {skip[DW-1], skip} : {(DW+1){1'b0}});
    if (sum_s[DW] != sum_s[DW-1]) begin
      sat_s = sum_s[DW] ? SAT_LO : SAT_HI;
    end else begin
      sat_s = sum_s[DW-1:0];
    end
  end

`ifdef WB_RELU_EN
  // Clamp negatives to zero after saturation.
  always_comb begin
    if (sat_s[DW-1]) begin
      post_data = {DW{1'b0}};
    end else begin
      post_data = sat_s;
    end
  end
`else
  assign post_data = sat_s;
`endif

endmodule

// File: rtl/wb_ctrl_l10_to_l16.sv
// Writeback controller for fire layers 10-16: counts result beats of one stage,
// generates write/skip addresses and bank, adds skip operand on stage 4.
// Optional macro WB_RELU_EN enables a ReLU clamp on every written value.
module wb_ctrl_l10_to_l16
  import wb_l10_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           stage_u,
  input  logic [2:0]           zmax,
  input  logic                 res_valid,
  input  logic signed [DW-1:0] res_data1,
  input  logic signed [DW-1:0] res_data2,
  output logic                 busy,
  output logic [AW-1:0]        skip_addr1,
  output logic [AW-1:0]        skip_addr2,
  input  logic signed [DW-1:0] skip_data1,
  input  logic signed [DW-1:0] skip_data2,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [AW-1:0]        wr_addr1,
  output logic [AW-1:0]        wr_addr2,
  output logic signed [DW-1:0] wr_data1,
  output logic signed [DW-1:0] wr_data2,
  output logic                 done,
  output logic                 err
);

  wb_state_t state_r, state_nxt_s;
  logic [2:0] stage_r, zmax_r, y_r, z_r;
  logic [1:0] xp_r;
  logic beat_s, last_s, start_ok_s, err_set_s;
  logic [AW-1:0] beat_addr_s;
  logic wr_en_r, wr_bank_r, skip_en_r, busy_r, done_r, err_r;
  logic [AW-1:0] wr_addr1_r, wr_addr2_r;
  logic signed [DW-1:0] res1_r, res2_r;

  assign beat_s      = (state_r == ST_ACTIVE) && res_valid;
  assign last_s      = beat_s && (xp_r == XP_LAST) && (y_r == Y_LAST) && (z_r == zmax_r);
  assign start_ok_s  = (state_r == ST_IDLE) && start && (stage_u <= U_MAX);
  assign err_set_s   = (res_valid && (state_r != ST_ACTIVE)) ||
                       (start && (state_r != ST_IDLE)) ||
                       (start && (state_r == ST_IDLE) && (stage_u > U_MAX));
  assign beat_addr_s = AW'({z_r, y_r, xp_r, 1'b0});
  assign skip_addr1  = beat_addr_s;
  assign skip_addr2  = beat_addr_s | AW'(1);

  // Next-state logic for the stage sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (start_ok_s) state_nxt_s = ST_ACTIVE; else state_nxt_s = ST_IDLE;
      ST_ACTIVE: if (last_s) state_nxt_s = ST_DRAIN; else state_nxt_s = ST_ACTIVE;
      ST_DRAIN:  state_nxt_s = ST_DONE;
      ST_DONE:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Stage parameters and beat counters (xp fastest, then y, then z).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_r <= 3'd0;
      zmax_r  <= 3'd0;
      xp_r    <= 2'd0;
      y_r     <= 3'd0;
      z_r     <= 3'd0;
    end else if (start_ok_s) begin
      stage_r <= stage_u;
      zmax_r  <= zmax;
      xp_r    <= 2'd0;
      y_r     <= 3'd0;
      z_r     <= 3'd0;
    end else if (beat_s) begin
      xp_r <= xp_r + 2'd1;
      if (xp_r == XP_LAST) begin
        y_r <= y_r + 3'd1;
        if (y_r == Y_LAST) z_r <= z_r + 3'd1;
      end
    end
  end

  // Write-side registers; data is finished next cycle once skip data returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r    <= 1'b0;
      wr_bank_r  <= 1'b0;
      wr_addr1_r <= {AW{1'b0}};
      wr_addr2_r <= {AW{1'b0}};
      res1_r     <= {DW{1'b0}};
      res2_r     <= {DW{1'b0}};
      skip_en_r  <= 1'b0;
    end else begin
      wr_en_r   <= beat_s;
      skip_en_r <= beat_s && (stage_r == U_SKIP);
      if (beat_s) begin
        wr_bank_r  <= ~stage_r[0];
        wr_addr1_r <= beat_addr_s;
        wr_addr2_r <= beat_addr_s | AW'(1);
        res1_r     <= res_data1;
        res2_r     <= res_data2;
      end
    end
  end

  // Status flags; err is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == ST_ACTIVE) || (state_nxt_s == ST_DRAIN);
      done_r <= (state_nxt_s == ST_DONE);
      err_r  <= err_r | err_set_s;
    end
  end

  wb_lane_post #(.DW(DW)) u_lane1 (
    .res(res1_r), .skip(skip_data1), .skip_en(skip_en_r), .post_data(wr_data1)
  );

  wb_lane_post #(.DW(DW)) u_lane2 (
    .res(res2_r), .skip(skip_data2), .skip_en(skip_en_r), .post_data(wr_data2)
  );

  assign wr_en    = wr_en_r;
  assign wr_bank  = wr_bank_r;
  assign wr_addr1 = wr_addr1_r;
  assign wr_addr2 = wr_addr2_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_wb_ctrl_l10_to_l16.sv
// Directed self-checking bench for wb_ctrl_l10_to_l16 (honours WB_RELU_EN).
module tb_wb_ctrl_l10_to_l16;
  localparam int DW = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, res_valid, busy, wr_en, wr_bank, done, err;
  logic [2:0] stage_u, zmax;
  logic [DW-1:0] res_data1, res_data2, skip_data1, skip_data2, wr_data1, wr_data2;
  logic [AW-1:0] skip_addr1, skip_addr2, wr_addr1, wr_addr2;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] skip_mem [0:1023];
  logic [DW-1:0] vr [3];
  logic [DW-1:0] vs [3];
  logic [DW-1:0] ve [3];

  wb_ctrl_l10_to_l16 #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stage_u(stage_u), .zmax(zmax),
    .res_valid(res_valid), .res_data1(res_data1), .res_data2(res_data2),
    .busy(busy), .skip_addr1(skip_addr1), .skip_addr2(skip_addr2),
    .skip_data1(skip_data1), .skip_data2(skip_data2),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2), .done(done), .err(err)
  );

  // Synchronous-read skip BRAM: data for an address appears one cycle later.
  always @(posedge clk) begin
    skip_data1 <= skip_mem[skip_addr1];
    skip_data2 <= skip_mem[skip_addr2];
  end

  task automatic do_start(input logic [2:0] stg, input logic [2:0] zm);
    start = 1'b1; stage_u = stg; zmax = zm;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy: got %b exp 1", busy); end
  endtask

  // mode 0: ramp pass-through, 1: stage-4 saturation table, 2: negative/positive pair
  task automatic run_beats(input logic [2:0] stg, input logic [2:0] zm, input int mode,
                           input bit gaps, input int stop_after, input logic exp_err);
    int nb, lim, k1, k2;
    logic [DW-1:0] r1, r2, e1, e2;
    logic [AW-1:0] ea;
    logic eb;
    nb = 32 * (int'(zm) + 1);
    lim = (stop_after > 0) ? stop_after : nb;
    eb = ~stg[0];
    for (int i = 0; i < lim; i++) begin
      ea = AW'(2 * i);
      skip_mem[2*i] = 16'h1234; skip_mem[2*i+1] = 16'h4321;
      case (mode)
        0: begin r1 = DW'(i); r2 = 16'h1000 + DW'(i); e1 = r1; e2 = r2; end
        1: begin
          k1 = i % 3; k2 = (i + 1) % 3;
          r1 = vr[k1]; skip_mem[2*i] = vs[k1]; e1 = ve[k1];
          r2 = vr[k2]; skip_mem[2*i+1] = vs[k2]; e2 = ve[k2];
        end
        default: begin
          r1 = 16'hFFF9; r2 = 16'h0009; e2 = 16'h0009;
`ifdef WB_RELU_EN
          e1 = 16'h0000;
`else
          e1 = 16'hFFF9;
`endif
        end
      endcase
      res_data1 = r1; res_data2 = r2; res_valid = 1'b1;
      @(negedge clk);
      checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL wr_en beat %0d: got %b exp 1", i, wr_en); end
      checks++; if (wr_addr1 !== ea) begin failures++; $display("FAIL wr_addr1 beat %0d: got %h exp %h", i, wr_addr1, ea); end
      checks++; if (wr_addr2 !== (ea | AW'(1))) begin failures++; $display("FAIL wr_addr2 beat %0d: got %h exp %h", i, wr_addr2, ea | AW'(1)); end
      checks++; if (wr_bank !== eb) begin failures++; $display("FAIL wr_bank beat %0d: got %b exp %b", i, wr_bank, eb); end
      checks++; if (wr_data1 !== e1) begin failures++; $display("FAIL wr_data1 beat %0d: got %h exp %h", i, wr_data1, e1); end
      checks++; if (wr_data2 !== e2) begin failures++; $display("FAIL wr_data2 beat %0d: got %h exp %h", i, wr_data2, e2); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL busy_done beat %0d: got %b%b exp 10", i, busy, done); end
      if (gaps && i < lim - 1 && $urandom_range(0, 2) == 0) begin
        res_valid = 1'b0;
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL gap_wr_en beat %0d: got %b exp 0", i, wr_en); end
      end
    end
    res_valid = 1'b0;
    if (stop_after == 0) begin
      @(negedge clk);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_pulse: got %b exp 1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_fall: got %b exp 0", busy); end
      checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL wr_en_done: got %b exp 0", wr_en); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_width: got %b exp 0", done); end
      checks++; if (err !== exp_err) begin failures++; $display("FAIL err_end: got %b exp %b", err, exp_err); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; res_valid = 1'b0; stage_u = 3'd0; zmax = 3'd0;
    res_data1 = 16'h0000; res_data2 = 16'h0000;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, wr_en, wr_bank, done, err} !== 5'b0) begin failures++; $display("FAIL reset_flags: got %b exp 00000", {busy, wr_en, wr_bank, done, err}); end
    checks++; if ({wr_addr1, wr_addr2} !== {2*AW{1'b0}}) begin failures++; $display("FAIL reset_addr: got %h %h exp 0 0", wr_addr1, wr_addr2); end
    checks++; if ({wr_data1, wr_data2} !== {2*DW{1'b0}}) begin failures++; $display("FAIL reset_data: got %h %h exp 0 0", wr_data1, wr_data2); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stage0_back_to_back();
    do_start(3'd0, 3'd0);
    run_beats(3'd0, 3'd0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_stage3_gaps();
    do_start(3'd3, 3'd2);
    run_beats(3'd3, 3'd2, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stage4_sat();
    do_start(3'd4, 3'd0);
    run_beats(3'd4, 3'd0, 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_relu_stage2();
    do_start(3'd2, 3'd0);
    run_beats(3'd2, 3'd0, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_errors();
    rst = 1'b0; #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_reset: got %b exp 0", err); end
    @(negedge clk); rst = 1'b1;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_beat: got wr_en=%b busy=%b exp 0 0", wr_en, busy); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL idle_beat_err: got %b exp 1", err); end
    start = 1'b1; stage_u = 3'd5; zmax = 3'd0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_stage_busy: got %b exp 0", busy); end
    do_start(3'd1, 3'd0);
    start = 1'b1; stage_u = 3'd0; zmax = 3'd3;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || wr_en !== 1'b0) begin failures++; $display("FAIL active_start: got busy=%b wr_en=%b exp 1 0", busy, wr_en); end
    run_beats(3'd1, 3'd0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_stage();
    do_start(3'd1, 3'd0);
    run_beats(3'd1, 3'd0, 0, 1'b0, 10, 1'b0);
    res_data1 = 16'h00AA; res_data2 = 16'h00BB; res_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, wr_en, wr_bank, done, err} !== 5'b0) begin failures++; $display("FAIL midrst_flags: got %b exp 00000", {busy, wr_en, wr_bank, done, err}); end
    checks++; if ({wr_addr1, wr_data1} !== {(AW+DW){1'b0}}) begin failures++; $display("FAIL midrst_out: got %h %h exp 0 0", wr_addr1, wr_data1); end
    res_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_nodone: got done=%b busy=%b exp 0 0", done, busy); end
    do_start(3'd1, 3'd0);
    run_beats(3'd1, 3'd0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) skip_mem[a] = 16'h1234;
    vr[0] = 16'h7000; vs[0] = 16'h2000; ve[0] = 16'h7FFF;
    vr[1] = 16'h8001; vs[1] = 16'hFFF0;
`ifdef WB_RELU_EN
    ve[1] = 16'h0000;
`else
    ve[1] = 16'h8000;
`endif
    vr[2] = 16'h0005; vs[2] = 16'hFFFD; ve[2] = 16'h0002;
    test_reset();
    test_stage0_back_to_back();
    test_stage3_gaps();
    test_stage4_sat();
    test_relu_stage2();
    test_errors();
    test_reset_mid_stage();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_ctrl_l10_to_l16.md
# wb_ctrl_l10_to_l16

Output writeback controller for fire layers 10–16. It is the write-side counterpart of the layer 10–16 read controller. It accepts two-lane convolution results from the PE datapath for one stage (u = 0..4) and generates BRAM write addresses, bank select and write enables. On stage 4 it also fetches the skip-connection operand and adds it with saturation before the write. One `done` pulse per stage releases the read controller to advance to the next stage.

## Interface
Parameters:
- `DW`, 16, signed data width of results, skip operand and written data
- `AW`, 10, BRAM address width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a stage; honoured only in IDLE
- `stage_u`  in  3  stage index 0..4, latched on accepted `start`
- `zmax`  in  3  last channel-group index for this stage, latched on accepted `start`
- `res_valid`  in  1  result beat present; no backpressure from the datapath
- `res_data1`, `res_data2`  in  DW each  lane results for pixels (2·xp, y) and (2·xp+1, y)
- `busy`  out  1  high in ACTIVE and DRAIN
- `skip_addr1`, `skip_addr2`  out  AW each  skip BRAM read addresses; data returns 1 cycle later
- `skip_data1`, `skip_data2`  in  DW each  skip BRAM read data
- `wr_en`  out  1  write strobe for both lanes
- `wr_bank`  out  1  0 = BRAM1, 1 = BRAM2
- `wr_addr1`, `wr_addr2`  out  AW each  write addresses
- `wr_data1`, `wr_data2`  out  DW each  write data
- `done`  out  1  one-cycle pulse at stage end
- `err`  out  1  sticky protocol-error flag; cleared only by reset

## Operation
FSM states: IDLE, ACTIVE, DRAIN, DONE.
- IDLE → ACTIVE on `start`. Latch `stage_u` and `zmax`. Clear counters xp (2b), y (3b) and z (3b).
- ACTIVE: each `res_valid` is one beat.
  - Counter order: xp fastest, then y, then z. This gives 32 beats per channel group and 32·(zmax+1) beats per stage.
  - Last beat: xp=3, y=7, z=zmax. On that beat the FSM goes ACTIVE → DRAIN.
- DRAIN: lasts exactly 1 cycle while the final write retires, then goes to DONE.
- DONE: `done`=1 for 1 cycle, then IDLE.

Addressing:
- Beat address `wr_addr1 = {1'b0, z, y, xp, 1'b0}` and `wr_addr2 = wr_addr1 | 1`.
- `skip_addr1/2` equal the same beat address, driven combinationally from the counters in the beat cycle.

Bank select:
- `wr_bank = ~stage_u[0]`. Stages 0, 2, 4 write BRAM2; stages 1 and 3 write BRAM1.

Data path:
- Stage 4: `wr_data = sat(res_data + skip_data)`. The sum is formed in DW+1 bits and saturated to signed DW, so the result is clamped to [−2^(DW−1), 2^(DW−1)−1].
- Stages 0–3: `wr_data = res_data`, and the skip path is ignored.

Error cases (all set `err`):
- `res_valid` outside ACTIVE: beat dropped, no write.
- `start` while not IDLE: ignored.
- `stage_u` > 4 on `start`: `start` rejected, FSM stays IDLE.

Reset:
- Asynchronous assertion mid-stage forces IDLE immediately and aborts the partial stage. No `done` is issued.

## Timing
- Reset values: `busy`=0, `wr_en`=0, `wr_bank`=0, all addresses and data 0, `done`=0, `err`=0, state IDLE.
- Latency: beat at cycle n produces registered `wr_en`/`wr_addr*`/`wr_data*` at cycle n+1, uniformly for all stages.
- `wr_en` is low in every cycle not following a beat.
- Back-to-back beats on consecutive cycles sustain one write per cycle.
- Final beat at cycle n: write at n+1 (DRAIN), `done` at n+2.
- `busy` rises the cycle after `start` and falls with the `done` cycle.
- Counter wrap: xp 3→0 increments y; y 7→0 increments z. z never wraps because the last beat ends the stage.

## Configuration
- `WB_RELU_EN` defined: the final written value is `max(0, value)` in every stage, applied after the skip add and saturation.
- Undefined: values are written unmodified (saturation only on stage 4).

## Structure
- Package `wb_l10_pkg`:
  - FSM state enum
  - `FMAP_DIM`=8, `XP_LAST`=3, `Y_LAST`=7, `U_SKIP`=4, `U_MAX`=4
  - saturation bounds as functions of DW
- Sub-module `wb_lane_post`: one per lane, instantiated twice. It performs the skip add enable, DW+1 add, saturate and optional ReLU, and is purely combinational.

## Test plan
- Stage 0, zmax=0: start, then 32 consecutive beats → 32 writes to bank 1, addresses 0..63 in lane pairs, `done` 2 cycles after the last beat, `err`=0.
- Stage 3, zmax=2 with random gaps in `res_valid` → 96 writes to bank 0. The last write has `wr_addr1`=0x0BE, `wr_addr2`=0x0BF, and `done` follows exactly.
- Stage 4 with res=0x7000 and skip=0x2000 → 0x7FFF. With res=0x8001 and skip=0xFFF0 → 0x8000. With res=5 and skip=−3 → 2.
- With `WB_RELU_EN`, stage 2 res=−7 → 0 and res=9 → 9. Without it, −7 is written as −7.
- `res_valid` in IDLE, `start` in ACTIVE, and `start` with `stage_u`=5 → no writes, state unaffected, `err`=1 and stays set.
- Assert `rst` after beat 10 of stage 1 → outputs 0 and state IDLE within the same cycle. A fresh start then restarts the addresses at 0.
